if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the rv32i pipeline. Owns the program counter, drives the byte address into the combinational instruction ROM, and captures the returned 32-bit instruction into the IF/ID pipeline register. Responds to stall, flush and control-flow redirect requests from the hazard unit and the execute stage. Keeps a sticky misaligned-redirect flag and a retired-fetch counter for debug.

## Interface

- `XLEN`, `riscv_pkg::XLEN`: address/data width.
- `RESET_PC`, `0`: PC value loaded on reset.
- `CNT_W`, `32`: width of `fetch_count`.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `stall_f`  in  1  hold PC (from hazard unit).
- `stall_d`  in  1  hold IF/ID register.
- `flush_d`  in  1  squash IF/ID register (turn it into a bubble).
- `redirect_valid`  in  1  taken branch or jump resolved in EX.
- `redirect_pc`  in  XLEN  redirect target byte address.
- `imem_addr`  out  XLEN  byte address to the instruction ROM. Equal to `pc_f`.
- `imem_rdata`  in  32  instruction returned combinationally by the ROM.
- `pc_f`  out  XLEN  current fetch PC.
- `pc_d`  out  XLEN  PC of the instruction in ID.
- `pc_plus4_d`  out  XLEN  `pc_d + 4`.
- `instr_d`  out  32  instruction in ID.
- `valid_d`  out  1  ID holds a real instruction. 0 means bubble.
- `misalign_err`  out  1  sticky: a redirect target had `[1:0] != 0`.
- `fetch_count`  out  CNT_W  count of instructions accepted into ID.

## Operation

- **PC update**, evaluated at each rising edge, in priority order:
  - `redirect_valid` high: `pc_f <= {redirect_pc[XLEN-1:2], 2'b00}`. Redirect overrides `stall_f`.
  - `stall_f` high: `pc_f` holds.
  - Otherwise: `pc_f <= pc_f + 4`. Arithmetic is modulo 2^XLEN, so `0xFFFF_FFFC` wraps to `0`.
- **IF/ID register**, evaluated at each rising edge, in priority order:
  - `flush_d` high: `instr_d <= INSTR_NOP`, `valid_d <= 0`. `pc_d` and `pc_plus4_d` load the current F values. Flush overrides `stall_d`.
  - `stall_d` high: all D outputs hold.
  - Otherwise: `instr_d <= imem_rdata`, `pc_d <= pc_f`, `pc_plus4_d <= pc_f + 4`, `valid_d <= 1`.
- **Redirect without flush**: when `redirect_valid` is high, the wrong-path instruction in F is still loaded into D unless `flush_d` is also high. The hazard unit asserts both together; this block does not infer the flush.
- **misalign_err**: set at the edge where `redirect_valid` is high and `redirect_pc[1:0] != 0`. Cleared only by `rst`.
- **fetch_count**: increments by 1 at each edge where D loads a real instruction (not flushed, not stalled). Wraps at 2^CNT_W.
- **Reset mid-operation**: `rst` forces every register to its reset value immediately, without waiting for a clock edge. The first fetch after deassertion is from `RESET_PC`.

## Timing

- **Reset values**:
  - `pc_f = imem_addr = RESET_PC`
  - `pc_d = 0`, `pc_plus4_d = 0`
  - `instr_d = INSTR_NOP`
  - `valid_d = 0`, `misalign_err = 0`, `fetch_count = 0`
- **Read path**: the ROM is combinational, so `imem_rdata` for `pc_f` is valid in the same cycle. Fetch-to-ID latency is one cycle.
- **Throughput**: one instruction per cycle when there are no stalls.
- **Redirect penalty**:
  - The target PC appears on `pc_f` the cycle after `redirect_valid`.
  - The target instruction appears in D two cycles after `redirect_valid`.
- **Stall pairing**: `stall_f` and `stall_d` are normally asserted together (load-use). If `stall_d` is high while `stall_f` is low, the instruction fetched in that cycle is lost. This is legal and not checked.
- **Input timing**: all inputs are sampled only at the rising edge. No combinational path from inputs to outputs, except `imem_addr = pc_f`.

## Test plan

1. **Reset and sequential fetch.** Hold `rst` for 2 cycles, then release; ROM returns word index. Expect:
   - `pc_f` = 0, 4, 8, 12.
   - `instr_d` shows word 0 one cycle after release.
   - `valid_d = 1` and `fetch_count = 4` after 4 edges.
2. **Load-use stall.** Assert `stall_f` and `stall_d` for 1 cycle at `pc_f = 0x10`. Expect:
   - `pc_f` stays at `0x10` for 2 cycles.
   - `instr_d` and `pc_d = 0x0C` hold.
   - `fetch_count` does not increment on the stalled edge.
3. **Taken branch.** At `pc_f = 0x18`, assert `redirect_valid` with `redirect_pc = 0x40` plus `flush_d`. Expect:
   - Next cycle: `pc_f = 0x40`, `valid_d = 0`, `instr_d = INSTR_NOP`.
   - Following cycle: `pc_d = 0x40`, `valid_d = 1`.
4. **Simultaneous events.** Assert `redirect_valid` (`redirect_pc = 0x80`), `stall_f`, `stall_d` and `flush_d` in the same cycle. Expect `pc_f = 0x80` and `valid_d = 0`.
5. **Misaligned redirect.** Use `redirect_pc = 0x22`. Expect:
   - `pc_f = 0x20`.
   - `misalign_err = 1`, and it stays 1 after later normal fetches.
   - Only `rst` clears it.
6. **Async reset and wrap-around.**
   - Assert `rst` between clock edges while running at `pc_f = 0x30`. Expect all outputs at reset values immediately, before the next edge.
   - Separately, set `RESET_PC = 0xFFFF_FFFC`. Expect the next `pc_f = 0` and `pc_plus4_d = 0` for that instruction.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, ROM address drive and the IF/ID
// pipeline register, plus a sticky misaligned-redirect flag and a counter of
// instructions accepted into ID.

package riscv_pkg;
  parameter int unsigned XLEN = 32;
  // Canonical rv32i NOP: addi x0, x0, 0
  parameter logic [31:0] INSTR_NOP = 32'h0000_0013;
endpackage

module if_stage #(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic             stall_d,
  input  logic             flush_d,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [XLEN-1:0]  pc_f,
  output logic [XLEN-1:0]  pc_d,
  output logic [XLEN-1:0]  pc_plus4_d,
  output logic [31:0]      instr_d,
  output logic             valid_d,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_count
);

  logic [XLEN-1:0] pc_plus4_f;
  logic [XLEN-1:0] redirect_target;
  logic            load_d;

  assign imem_addr       = pc_f;
  // Modulo-2^XLEN add: the top of the address space wraps to zero.
  assign pc_plus4_f      = pc_f + XLEN'(4);
  // Low two bits are dropped; a misaligned target is flagged, not trapped.
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  // D accepts a real instruction only when neither flushed nor stalled.
  assign load_d          = !flush_d && !stall_d;

  // Fetch PC: redirect beats stall, otherwise advance by one word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f <= RESET_PC;
    end else if (redirect_valid) begin
      pc_f <= redirect_target;
    end else if (!stall_f) begin
      pc_f <= pc_plus4_f;
    end
  end

  // IF/ID register: flush inserts a bubble and beats stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_d       <= '0;
      pc_plus4_d <= '0;
      instr_d    <= riscv_pkg::INSTR_NOP;
      valid_d    <= 1'b0;
    end else if (flush_d) begin
      pc_d       <= pc_f;
      pc_plus4_d <= pc_plus4_f;
      instr_d    <= riscv_pkg::INSTR_NOP;
      valid_d    <= 1'b0;
    end else if (!stall_d) begin
      pc_d       <= pc_f;
      pc_plus4_d <= pc_plus4_f;
      instr_d    <= imem_rdata;
      valid_d    <= 1'b1;
    end
  end

  // Sticky flag for any redirect whose target is not word aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end

  // Debug counter of instructions accepted into ID; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
    end else if (load_d) begin
      fetch_count <= fetch_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed test-plan sequence followed by randomized
// stall/flush/redirect traffic, scored against a cycle-level reference model.

module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f, stall_d, flush_d, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_rdata, pc_f, pc_d, pc_plus4_d, instr_d;
  logic        valid_d, misalign_err;
  logic [31:0] fetch_count;

  logic [31:0] w_addr, w_rdata, w_pc_f, w_pc_d, w_pc4, w_instr, w_cnt;
  logic        w_valid, w_mis;

  always #5 clk = ~clk;

  // ROM returns the word index of the address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  assign imem_rdata = rom(imem_addr);
  assign w_rdata    = rom(w_addr);

  if_stage #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .pc_f(pc_f), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .instr_d(instr_d), .valid_d(valid_d),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  // Second instance exercising PC wrap from the top of the address space.
  if_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(32)) u_wrap (
    .clk(clk), .rst(rst), .stall_f(1'b0), .stall_d(1'b0),
    .flush_d(1'b0), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .pc_f(w_pc_f), .pc_d(w_pc_d),
    .pc_plus4_d(w_pc4), .instr_d(w_instr), .valid_d(w_valid),
    .misalign_err(w_mis), .fetch_count(w_cnt)
  );

  typedef struct packed {
    logic [31:0] pc_f;
    logic [31:0] pc_d;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic        mis;
    logic [31:0] cnt;
  } snap_t;

  snap_t q[$];
  snap_t m;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic compare_snap(input snap_t s);
    chk("pc_f",         pc_f,                 s.pc_f);
    chk("imem_addr",    imem_addr,            s.pc_f);
    chk("pc_d",         pc_d,                 s.pc_d);
    chk("pc_plus4_d",   pc_plus4_d,           s.pc4);
    chk("instr_d",      instr_d,              s.instr);
    chk("valid_d",      {31'b0, valid_d},     {31'b0, s.valid});
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, s.mis});
    chk("fetch_count",  fetch_count,          s.cnt);
  endtask

  function automatic void model_reset();
    m.pc_f  = 32'h0;
    m.pc_d  = 32'h0;
    m.pc4   = 32'h0;
    m.instr = NOP;
    m.valid = 1'b0;
    m.mis   = 1'b0;
    m.cnt   = 32'h0;
  endfunction

  // Reference behaviour of one rising edge, from the documented priority rules.
  function automatic void model_edge();
    logic [31:0] old_pc;
    if (rst) begin
      model_reset();
      return;
    end
    old_pc = m.pc_f;
    if (flush_d) begin
      m.instr = NOP;
      m.valid = 1'b0;
      m.pc_d  = old_pc;
      m.pc4   = old_pc + 32'd4;
    end else if (!stall_d) begin
      m.instr = rom(old_pc);
      m.valid = 1'b1;
      m.pc_d  = old_pc;
      m.pc4   = old_pc + 32'd4;
      m.cnt   = m.cnt + 32'd1;
    end
    if (redirect_valid) begin
      m.pc_f = (redirect_pc / 4) * 4;
      if (redirect_pc % 4 != 0) m.mis = 1'b1;
    end else if (!stall_f) begin
      m.pc_f = old_pc + 32'd4;
    end
  endfunction

  // Monitor: compare each expected snapshot at the falling edge after its edge.
  always @(negedge clk) begin
    if (q.size() > 0) compare_snap(q.pop_front());
  end

  task automatic step(input logic rv, input logic [31:0] rp,
                      input logic sf, input logic sd, input logic fl);
    redirect_valid = rv;
    redirect_pc    = rp;
    stall_f        = sf;
    stall_d        = sd;
    flush_d        = fl;
    @(posedge clk);
    #1;
    model_edge();
    q.push_back(m);
  endtask

  // Reset asserted mid-cycle, after the monitor has compared, before next edge.
  task automatic async_rst();
    #6;
    rst = 1'b1;
    #1;
    model_reset();
    compare_snap(m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic rv, sf, sd, fl;
    logic [31:0] rp;
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    model_reset();

    // 1: reset held two edges, then sequential fetch
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("wrap_reset_pc", w_pc_f, 32'hFFFF_FFFC);
    rst = 1'b0;
    step(0, 0, 0, 0, 0);
    chk("wrap_pc_f", w_pc_f, 32'h0);
    chk("wrap_pc_plus4_d", w_pc4, 32'h0);
    chk("wrap_pc_d", w_pc_d, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // 2: load-use stall at pc_f = 0x10
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // 3: taken branch from 0x18 to 0x40 with flush
    step(1, 32'h40, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // 4: redirect, both stalls and flush together
    step(1, 32'h80, 1, 1, 1);
    step(0, 0, 0, 0, 0);
    // 5: misaligned redirect, flag must stick
    step(1, 32'h22, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // 6: async reset while running at 0x30
    step(1, 32'h30, 0, 0, 1);
    async_rst();
    step(0, 0, 0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Randomized traffic, including wrapping and misaligned targets
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 7) == 0);
      rp = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
      sf = ($urandom_range(0, 4) == 0);
      sd = sf ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      fl = rv ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      step(rv, rp, sf, sd, fl);
      if (i % 100 == 57) begin
        async_rst();
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
      end
    end
    step(0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
